motoro3_line_step_pwm_gen: RTL and testbench
============================================

Name: motoro3_line_step_pwm_gen

Overview:
- Sequencer for one motor line: counts step and sub-step timing and drives `lcStep` and `m3LpwmSplitStep`.
- These two outputs feed the line parameter calculator, which is combinational and returns `slLen` (sub-step length) and `plLen` (PWM on-length).
- This block latches both values at each sub-step boundary.
- It produces the line PWM output and step/split indices for the phase driver.

Parameters:
- STEP_NUM, 12, steps per electrical cycle; `lcStep` wraps 0..STEP_NUM-1 (max 16).
- PWM_W, 12, width of PWM period counter and `m3r_pwmLenWant`/`m3r_pwmMinMask`.

Ports:
- clk  input  1  system clock
- nRst  input  1  async active-low reset
- m3r_run  input  1  1 = sequence runs; 0 = idle
- m3r_stepSplitMax  input  2  sub-steps per step minus 1
- m3r_pwmLenWant  input  12  PWM period in clocks
- m3r_pwmMinMask  input  12  minimum on-length; shorter pulses are suppressed
- slLen  input  16  sub-step length in clocks, from the calculator
- plLen  input  16  PWM on-length in clocks, from the calculator
- lcStep  output  4  current step index
- m3LpwmSplitStep  output  2  current sub-step index
- m3LpwmOut  output  1  line PWM
- m3LstepTick  output  1  one-cycle pulse on each `lcStep` change

Behaviour:
- Reset: one clock `clk`; reset `nRst` is asynchronous and active-low. While `nRst`=0:
  - `lcStep`=0, `m3LpwmSplitStep`=0, `m3LpwmOut`=0, `m3LstepTick`=0.
  - FSM=IDLE; all counters and latches = 0.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - `m3LpwmOut`=0; `lcStep` and split hold their values.
  - `m3r_run`=1 -> LOAD.
- LOAD (exactly 1 cycle):
  - Latch `slLen`→slLat and `plLen`→plLat. These are valid for the current `lcStep`/split, which were registered the previous cycle.
  - slLat = max(`slLen`, 1).
  - Clear subCnt and pwmCnt; `m3LpwmOut`=0.
  - Next state RUN, or IDLE if `m3r_run`=0.
- RUN, per cycle:
  - subCnt++.
  - pwmCnt++; pwmCnt wraps to 0 when pwmCnt ≥ `m3r_pwmLenWant`-1.
  - `m3LpwmOut` is registered: 1 iff (pwmCnt < plLat) AND (plLat ≥ `m3r_pwmMinMask`) AND (`m3r_pwmLenWant` ≠ 0).
  - If plLat ≥ `m3r_pwmLenWant`, output stays 1 for the whole sub-step.
- Sub-step boundary (RUN, subCnt = slLat-1):
  - If split ≥ `m3r_stepSplitMax`:
    - split←0.
    - `lcStep` advances and wraps STEP_NUM-1→0.
    - `m3LstepTick`=1 for the following cycle.
  - Else split←split+1.
  - Next state LOAD.
  - The ≥ compare means a `m3r_stepSplitMax` reduced mid-step wraps at the next boundary, not at 3.
- Run deassert:
  - `m3r_run`=0 in RUN or LOAD -> IDLE next cycle.
  - `m3LpwmOut` goes to 0 next cycle.
  - Index outputs hold their values.
  - A boundary coinciding with the deassert cycle still updates the indices.
- Latency:
  - `lcStep` changes 1 cycle after the boundary cycle.
  - The new `plLen` affects `m3LpwmOut` 2 cycles later (LOAD + register).
- Inputs `m3r_*` are used live except `slLen`/`plLen`, which are used only via the latches.
- Sub-step length in clocks = slLat + 1, where the +1 is the LOAD cycle.

Optional Feature:
- Macro: MOTORO3_LINE_REVERSE_EN.
- When defined:
  - Extra input port `m3r_dir` (1 bit) is present.
  - `m3r_dir`=1 decrements `lcStep` at step boundaries, wrapping 0→STEP_NUM-1.
  - `m3r_dir` is sampled at the boundary cycle.
- When undefined: the port is absent and `lcStep` always increments.

Test Plan:
- Reset behaviour: assert `nRst`=0 mid-RUN with `lcStep`=5 -> all outputs 0 immediately (asynchronous); after release the FSM is IDLE and `lcStep`=0.
- Step timing: `slLen`=10, `m3r_stepSplitMax`=1, `m3r_run`=1 -> `lcStep` increments every 22 clocks, split toggles every 11, `m3LstepTick` pulses once per `lcStep` change.
- Wrap: 12 steps pass -> sequence goes 11→0.
- PWM shape: `m3r_pwmLenWant`=8, `plLen`=3, `m3r_pwmMinMask`=2 -> pattern 3 high / 5 low; `plLen`=1 -> `m3LpwmOut` stays 0; `plLen`=20 -> constant 1.
- Degenerate lengths: `slLen`=0 -> treated as 1, step advances every 2 clocks per split; `m3r_pwmLenWant`=0 -> `m3LpwmOut`=0.
- Mid-step split change: `m3r_stepSplitMax` changes from 3 to 1 while split=2 -> at the next boundary split→0 and `lcStep` advances.
- Run deassert: drop `m3r_run` mid-sub-step -> `m3LpwmOut`=0 next cycle and indices hold.
- Reverse (with MOTORO3_LINE_REVERSE_EN): `m3r_dir`=1 from `lcStep`=0 -> 11, then 10.

Source files
------------

// File: rtl/motoro3_line_step_pwm_gen.sv
// Motor line step/sub-step sequencer with latched sub-step and PWM lengths.
// Optional MOTORO3_LINE_REVERSE_EN adds m3r_dir (1 = step index counts down).
module motoro3_line_step_pwm_gen #(
    parameter int unsigned STEP_NUM = 12,
    parameter int unsigned PWM_W    = 12
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             m3r_run,
    input  logic [1:0]       m3r_stepSplitMax,
    input  logic [PWM_W-1:0] m3r_pwmLenWant,
    input  logic [PWM_W-1:0] m3r_pwmMinMask,
    input  logic [15:0]      slLen,
    input  logic [15:0]      plLen,
`ifdef MOTORO3_LINE_REVERSE_EN
    input  logic             m3r_dir,
`endif
    output logic [3:0]       lcStep,
    output logic [1:0]       m3LpwmSplitStep,
    output logic             m3LpwmOut,
    output logic             m3LstepTick
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_step;
    logic [1:0]       r_split;
    logic [15:0]      r_subCnt;
    logic [PWM_W-1:0] r_pwmCnt;
    logic [15:0]      r_slLat;
    logic [15:0]      r_plLat;
    logic             r_pwmOut;
    logic             r_tick;

    logic             w_boundary;
    logic             w_pwmOn;
    logic [PWM_W-1:0] w_wantM1;
    logic [3:0]       w_stepInc;
    logic [3:0]       w_stepDec;
    logic [3:0]       w_stepNext;

    always_comb begin
        w_wantM1   = m3r_pwmLenWant - 1'b1;
        w_boundary = (r_state == S_RUN) && (r_subCnt == (r_slLat - 16'd1));
        w_pwmOn    = (32'(r_pwmCnt) < 32'(r_plLat))
                  && (32'(r_plLat) >= 32'(m3r_pwmMinMask))
                  && (m3r_pwmLenWant != '0);
        w_stepInc  = (r_step == 4'(STEP_NUM - 1)) ? '0 : r_step + 4'd1;
        w_stepDec  = (r_step == '0) ? 4'(STEP_NUM - 1) : r_step - 4'd1;
`ifdef MOTORO3_LINE_REVERSE_EN
        w_stepNext = m3r_dir ? w_stepDec : w_stepInc;
`else
        w_stepNext = w_stepInc;
`endif
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (m3r_run) w_next = S_LOAD;
            S_LOAD:  w_next = m3r_run ? S_RUN : S_IDLE;
            S_RUN: begin
                if (!m3r_run)       w_next = S_IDLE;
                else if (w_boundary) w_next = S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_step   <= '0;
            r_split  <= '0;
            r_subCnt <= '0;
            r_pwmCnt <= '0;
            r_slLat  <= '0;
            r_plLat  <= '0;
            r_pwmOut <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_tick   <= 1'b0;
            r_pwmOut <= 1'b0;
            unique case (r_state)
                S_LOAD: begin
                    // calculator outputs belong to the indices registered last cycle
                    r_slLat  <= (slLen == '0) ? 16'd1 : slLen;
                    r_plLat  <= plLen;
                    r_subCnt <= '0;
                    r_pwmCnt <= '0;
                end
                S_RUN: begin
                    r_subCnt <= r_subCnt + 16'd1;
                    r_pwmCnt <= (r_pwmCnt >= w_wantM1) ? '0 : r_pwmCnt + 1'b1;
                    r_pwmOut <= m3r_run & w_pwmOn;
                    if (w_boundary) begin
                        if (r_split >= m3r_stepSplitMax) begin
                            r_split <= '0;
                            r_step  <= w_stepNext;
                            r_tick  <= 1'b1;
                        end else begin
                            r_split <= r_split + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign lcStep          = r_step;
    assign m3LpwmSplitStep = r_split;
    assign m3LpwmOut       = r_pwmOut;
    assign m3LstepTick     = r_tick;

endmodule

// File: tb/tb_motoro3_line_step_pwm_gen.sv
// Self-checking bench: directed phases plus randomized traffic against a sub-step level reference.
module tb_motoro3_line_step_pwm_gen;
    localparam int STEP_NUM = 12;

    logic        clk = 1'b0;
    logic        nRst;
    logic        run;
    logic [1:0]  smax;
    logic [11:0] want;
    logic [11:0] mask;
    logic [15:0] sl;
    logic [15:0] pl;
`ifdef MOTORO3_LINE_REVERSE_EN
    logic        dir;
`endif
    logic [3:0]  lcStep;
    logic [1:0]  split;
    logic        pwmOut;
    logic        stepTick;

    always #5 clk = ~clk;

    motoro3_line_step_pwm_gen #(
        .STEP_NUM (STEP_NUM),
        .PWM_W    (12)
    ) dut (
        .clk              (clk),
        .nRst             (nRst),
        .m3r_run          (run),
        .m3r_stepSplitMax (smax),
        .m3r_pwmLenWant   (want),
        .m3r_pwmMinMask   (mask),
        .slLen            (sl),
        .plLen            (pl),
`ifdef MOTORO3_LINE_REVERSE_EN
        .m3r_dir          (dir),
`endif
        .lcStep           (lcStep),
        .m3LpwmSplitStep  (split),
        .m3LpwmOut        (pwmOut),
        .m3LstepTick      (stepTick)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: position within a sub-step (0 = load cycle, k+1 = k-th run cycle)
    bit m_active;
    int m_pos, m_sl, m_pl, m_step, m_split;
    bit m_out, m_tick;
    bit saw_wrap;
    int prev_step;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_sl = 0; m_pl = 0;
        m_step = 0; m_split = 0; m_out = 0; m_tick = 0;
    endtask

    task automatic model_edge();
        int k;
        int d;
        d = 0;
`ifdef MOTORO3_LINE_REVERSE_EN
        d = int'(dir);
`endif
        m_tick = 0;
        if (!m_active) begin
            m_out = 0;
            if (run) begin m_active = 1; m_pos = 0; end
        end else if (m_pos == 0) begin
            m_sl  = (sl == 0) ? 1 : int'(sl);
            m_pl  = int'(pl);
            m_out = 0;
            if (!run) m_active = 0; else m_pos = 1;
        end else begin
            k = m_pos - 1;
            m_out = 0;
            if (run && want != 0 && m_pl >= int'(mask))
                m_out = ((k % int'(want)) < m_pl);
            if (k == m_sl - 1) begin
                if (m_split >= int'(smax)) begin
                    m_split = 0;
                    m_step  = d ? (m_step + STEP_NUM - 1) % STEP_NUM : (m_step + 1) % STEP_NUM;
                    m_tick  = 1;
                end else begin
                    m_split = m_split + 1;
                end
                m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
            end
            if (!run) m_active = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!nRst) model_reset();
        else       model_edge();
        #1;
        cyc++;
        chk("lcStep", 32'(lcStep), 32'(m_step));
        chk("split", 32'(split), 32'(m_split));
        chk("pwmOut", 32'(pwmOut), 32'(m_out));
        chk("stepTick", 32'(stepTick), 32'(m_tick));
        if (prev_step == STEP_NUM - 1 && lcStep == 4'd0) saw_wrap = 1;
        prev_step = int'(lcStep);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Steady-state interval checks between step ticks and between split changes; counts PWM highs
    task automatic measure(input string tag, input int n, input int step_iv,
                           input int split_iv, output int highs);
        int last_s, last_p, nst, nsp;
        logic [1:0] prev_split;
        last_s = 0; last_p = 0; nst = 0; nsp = 0;
        prev_split = split;
        highs = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pwmOut === 1'b1) highs++;
            if (stepTick === 1'b1) begin
                if (nst >= 1) chk({tag, "_step_iv"}, 32'(cyc - last_s), 32'(step_iv));
                last_s = cyc; nst++;
            end
            if (split !== prev_split) begin
                if (nsp >= 1) chk({tag, "_split_iv"}, 32'(cyc - last_p), 32'(split_iv));
                last_p = cyc; nsp++;
                prev_split = split;
            end
        end
    endtask

    task automatic wait_step_tick(input string tag, input int maxc);
        bit found;
        found = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            tick();
            if (stepTick === 1'b1) found = 1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int highs, s_hold, p_hold;
        bit found;
        nRst = 0; run = 0; smax = 2'd1; want = 12'd8; mask = 12'd2; sl = 16'd10; pl = 16'd3;
`ifdef MOTORO3_LINE_REVERSE_EN
        dir = 0;
`endif
        saw_wrap = 0; prev_step = 0;
        model_reset();
        #1;
        chk("reset_lcStep", 32'(lcStep), 32'd0);
        chk("reset_pwmOut", 32'(pwmOut), 32'd0);
        ticks(3);
        nRst = 1;
        ticks(2);

        // step timing, wrap and 3-of-8 PWM shape
        run = 1;
        ticks(5);
        saw_wrap = 0;
        measure("timing", 12 * 22 + 22, 22, 11, highs);
        chk("wrap_11_to_0", 32'(saw_wrap), 32'd1);
        measure("pwm3", 88, 22, 11, highs);
        chk("pwm3_highs", 32'(highs), 32'd40);

        pl = 16'd1;
        ticks(25);
        measure("pwm1", 88, 22, 11, highs);
        chk("pwm_masked_highs", 32'(highs), 32'd0);

        pl = 16'd20;
        ticks(25);
        measure("pwm20", 88, 22, 11, highs);
        chk("pwm_full_highs", 32'(highs), 32'd80);

        // zero sub-step length behaves as one
        sl = 16'd0; pl = 16'd3;
        ticks(10);
        measure("sl0", 40, 4, 2, highs);

        // split limit lowered while split index is 2
        sl = 16'd2; smax = 2'd3;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (split == 2'd2) found = 1;
        end
        chk("wait_split2", 32'(found), 32'd1);
        smax = 2'd1;
        s_hold = int'(lcStep);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (split != 2'd2) found = 1;
        end
        chk("wait_split_change", 32'(found), 32'd1);
        chk("split_lowered_wraps", 32'(split), 32'd0);
        chk("split_lowered_step", 32'(lcStep), 32'((s_hold + 1) % STEP_NUM));

        // asynchronous reset in the middle of a run at step 5
        sl = 16'd10; pl = 16'd3;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (lcStep == 4'd5) found = 1;
        end
        chk("wait_step5", 32'(found), 32'd1);
        ticks(5);
        #2 nRst = 0;
        #1;
        chk("async_rst_lcStep", 32'(lcStep), 32'd0);
        chk("async_rst_split", 32'(split), 32'd0);
        chk("async_rst_pwmOut", 32'(pwmOut), 32'd0);
        chk("async_rst_tick", 32'(stepTick), 32'd0);
        model_reset();
        ticks(2);
        run = 0;
        nRst = 1;
        ticks(4);

        // run deassert mid sub-step
        run = 1;
        ticks(30);
        wait_step_tick("wait_tick_deassert", 30);
        ticks(4);
        run = 0;
        s_hold = int'(lcStep);
        p_hold = int'(split);
        tick();
        chk("deassert_pwm", 32'(pwmOut), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("deassert_hold_step", 32'(lcStep), 32'(s_hold));
            chk("deassert_hold_split", 32'(split), 32'(p_hold));
        end

        // zero PWM period keeps output low
        want = 12'd0; pl = 16'd5; mask = 12'd0;
        run = 1;
        measure("want0", 66, 22, 11, highs);
        chk("want0_highs", 32'(highs), 32'd0);
        run = 0;
        ticks(2);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (!m_active) want = 12'($urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) sl = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) pl = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) mask = 12'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) smax = 2'($urandom_range(0, 3));
            run = ($urandom_range(0, 19) != 0);
`ifdef MOTORO3_LINE_REVERSE_EN
            if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
`endif
            tick();
        end

`ifdef MOTORO3_LINE_REVERSE_EN
        run = 0;
        nRst = 0;
        ticks(2);
        nRst = 1;
        dir = 1; sl = 16'd1; smax = 2'd0; want = 12'd8;
        run = 1;
        wait_step_tick("wait_rev1", 20);
        chk("reverse_first", 32'(lcStep), 32'd11);
        wait_step_tick("wait_rev2", 20);
        chk("reverse_second", 32'(lcStep), 32'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
